// File: rtl/bus_cycle_gen_if.sv
// bus_cycle_gen_if: processor-side request/response handshake of the bus-cycle generator
interface bus_cycle_gen_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_io;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_io, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_io, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/bus_cycle_gen.sv
// bus_cycle_gen: runs one 8088-style T1-T2-T3-(TW)-T4 bus cycle per accepted byte request
module bus_cycle_gen #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    bus_cycle_gen_if.slave    req,
    output logic              ALE,
    output logic              IOM,
    output logic              RD,
    output logic              WR,
    output logic [ADDR_W-1:0] Address,
    inout  wire  [DATA_W-1:0] Data,
    input  logic              READY
);
    typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4} state_t;

    state_t            r_state;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic              r_data_oe;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_ale;
    logic              r_iom;
    logic              r_rd;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic              w_hs;

    assign w_hs = req.req_valid && r_req_ready;

    // every pin comes straight from a flop, so req_* never reaches the bus combinationally
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_data_oe   <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_ale       <= 1'b0;
            r_iom       <= 1'b0;
            r_rd        <= 1'b1;
            r_wr        <= 1'b1;
            r_addr      <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE, T4: begin
                    if (w_hs) begin
                        r_state     <= T1;
                        r_req_ready <= 1'b0;
                        r_ale       <= 1'b1;
                        r_write     <= req.req_write;
                        r_iom       <= req.req_io;
                        r_addr      <= req.req_addr;
                        r_wdata     <= req.req_wdata;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                T1: begin
                    r_state   <= T2;
                    r_ale     <= 1'b0;
                    r_rd      <= r_write;
                    r_wr      <= !r_write;
                    r_data_oe <= r_write;
                end
                T2: r_state <= T3;
                T3, TW: begin
                    if (READY) begin
                        r_state     <= T4;
                        r_rd        <= 1'b1;
                        r_wr        <= 1'b1;
                        r_data_oe   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_req_ready <= 1'b1;
                        r_rsp_rdata <= r_write ? r_rsp_rdata : Data;
                    end else begin
                        r_state <= TW;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req.req_ready = r_req_ready;
    assign req.rsp_valid = r_rsp_valid;
    assign req.rsp_rdata = r_rsp_rdata;
    assign ALE           = r_ale;
    assign IOM           = r_iom;
    assign RD            = r_rd;
    assign WR            = r_wr;
    assign Address       = r_addr;
    assign Data          = r_data_oe ? r_wdata : {DATA_W{1'bz}};
endmodule

// File: tb/tb_bus_cycle_gen.sv
// tb_bus_cycle_gen: directed bus-timing checks plus a randomized scoreboard run against a memory reference model
module tb_bus_cycle_gen;
    localparam int AW = 20;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          READY = 1'b1;
    logic          ALE, IOM, RD, WR;
    logic [AW-1:0] Address;
    wire  [DW-1:0] Data;

    bus_cycle_gen_if #(.ADDR_W(AW), .DATA_W(DW)) rq ();

    bus_cycle_gen #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RESET(RESET), .req(rq),
        .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR),
        .Address(Address), .Data(Data), .READY(READY)
    );

    always #5 CLK = ~CLK;

    // memory slave on the bus window 0x800xx; it ignores I/O cycles
    logic [7:0] smem [256];
    logic [7:0] ref_mem [256];
    wire slave_hit = (Address[19:8] == 12'h800) && !IOM;
    assign Data = (slave_hit && !RD) ? smem[Address[7:0]] : 8'hzz;
    always @(posedge CLK) if (slave_hit && !WR) smem[Address[7:0]] <= Data;

    typedef struct {bit rd; bit io; logic [7:0] exp;} exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0, rsp_cnt = 0, cyc = 0;
    bit rnd_ready = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET && rq.rsp_valid) begin
            rsp_cnt++;
            chk("rsp_bus_idle", {ALE, RD, WR}, 3'b011);
            if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                if (e.rd && !e.io) chk("rsp_rdata", rq.rsp_rdata, e.exp);
            end
        end
    end

    always @(negedge CLK) if (rnd_ready) READY = ($urandom_range(0, 3) != 0);

    // call at a falling edge; returns at the falling edge of T1
    task automatic issue(input bit w, input bit io, input logic [19:0] a, input logic [7:0] d);
        exp_t e;
        int n = 0;
        rq.req_valid = 1'b1; rq.req_write = w; rq.req_io = io; rq.req_addr = a; rq.req_wdata = d;
        while (!rq.req_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("req_wait_bound", n >= 100, 0);
        e.rd = !w; e.io = io; e.exp = ref_mem[a[7:0]];
        if (w && !io) ref_mem[a[7:0]] = d;
        sb.push_back(e);
        @(negedge CLK);
        rq.req_valid = 1'b0;
    endtask

    task automatic bus_at(input string name, input bit ale, iom, rd, wr, rv);
        chk(name, {ALE, IOM, RD, WR, rq.rsp_valid}, {ale, iom, rd, wr, rv});
        @(negedge CLK);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_bound", n >= 200, 0);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, c1;
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            smem[i] = v;
            ref_mem[i] = v;
        end
        smem[8'h10] = 8'h5A; ref_mem[8'h10] = 8'h5A;
        rq.req_valid = 0; rq.req_write = 0; rq.req_io = 0; rq.req_addr = '0; rq.req_wdata = '0;
        repeat (3) @(negedge CLK);
        chk("rst_req_ready", rq.req_ready, 1);
        chk("rst_rsp_valid", rq.rsp_valid, 0);
        chk("rst_rsp_rdata", rq.rsp_rdata, 0);
        chk("rst_pins", {ALE, IOM, RD, WR}, 4'b0011);
        chk("rst_address", Address, 0);
        RESET = 1'b0;
        @(negedge CLK);

        issue(0, 0, 20'h80010, 8'h00);
        chk("rd_addr_t1", Address, 20'h80010);
        bus_at("rd_t1", 1, 0, 1, 1, 0);
        bus_at("rd_t2", 0, 0, 0, 1, 0);
        bus_at("rd_t3", 0, 0, 0, 1, 0);
        chk("rd_addr_t4", Address, 20'h80010);
        bus_at("rd_t4", 0, 0, 1, 1, 1);
        bus_at("rd_after", 0, 0, 1, 1, 0);

        issue(1, 0, 20'h80020, 8'hC3);
        bus_at("wr_t1", 1, 0, 1, 1, 0);
        chk("wr_data_t2", Data, 8'hC3);
        bus_at("wr_t2", 0, 0, 1, 0, 0);
        chk("wr_data_t3", Data, 8'hC3);
        bus_at("wr_t3", 0, 0, 1, 0, 0);
        bus_at("wr_t4", 0, 0, 1, 1, 1);
        chk("wr_slave_mem", smem[8'h20], 8'hC3);
        issue(0, 0, 20'h80020, 8'h00);
        drain();

        c1 = rsp_cnt;
        issue(0, 0, 20'h80000, 8'h00);
        c0 = cyc;
        issue(0, 0, 20'h80001, 8'h00);
        chk("b2b_gap1", cyc - c0, 4);
        chk("b2b_ale1", ALE, 1);
        c0 = cyc;
        issue(0, 0, 20'h80002, 8'h00);
        chk("b2b_gap2", cyc - c0, 4);
        drain();
        chk("b2b_rsp_count", rsp_cnt - c1, 3);

        issue(0, 0, 20'h80005, 8'h00);
        READY = 1'b0;
        bus_at("ws_t1", 1, 0, 1, 1, 0);
        bus_at("ws_t2", 0, 0, 0, 1, 0);
        bus_at("ws_t3", 0, 0, 0, 1, 0);
        bus_at("ws_tw1", 0, 0, 0, 1, 0);
        READY = 1'b1;
        bus_at("ws_tw2", 0, 0, 0, 1, 0);
        bus_at("ws_t4", 0, 0, 1, 1, 1);

        issue(0, 0, 20'h80011, 8'h00);
        bus_at("ab_t1", 1, 0, 1, 1, 0);
        bus_at("ab_t2", 0, 0, 0, 1, 0);
        RESET = 1'b1;
        @(negedge CLK);
        chk("abort_state", {ALE, RD, WR, rq.req_ready, rq.rsp_valid}, 5'b01110);
        RESET = 1'b0;
        sb.delete();
        c1 = rsp_cnt;
        issue(0, 0, 20'h80010, 8'h00);
        drain();
        chk("post_reset_rsp", rsp_cnt - c1, 1);

        issue(1, 1, 20'h80030, 8'h77);
        bus_at("io_t1", 1, 1, 1, 1, 0);
        bus_at("io_t2", 0, 1, 1, 0, 0);
        bus_at("io_t3", 0, 1, 1, 0, 0);
        bus_at("io_t4", 0, 1, 1, 1, 1);
        chk("io_mem_untouched", smem[8'h30], ref_mem[8'h30]);

        rnd_ready = 1;
        repeat (150) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            issue(1'($urandom), $urandom_range(0, 7) == 0, 20'h80000 | 20'($urandom_range(0, 63)), 8'($urandom));
        end
        rnd_ready = 0;
        READY = 1'b1;
        drain();
        for (int i = 0; i < 64; i++) chk("final_mem", smem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
